chip_link_port: RTL

CHIP_LINK_PORT -- requirements
Module: chip_link_port

---
 rtl/chip_link_pkg.sv | 19 +
 rtl/link_fifo.sv | 57 +++++
 rtl/chip_link_port.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/chip_link_pkg.sv
// Shared link/router constants and the serializer state type for the chip-to-chip port.
package chip_link_pkg;

  localparam int FW_DEF = 36;
  localparam int PW_DEF = 9;
  localparam int NB_DEF = FW_DEF / PW_DEF;
  localparam int B_DEF  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Index width that stays legal (>= 1 bit) for single-entry structures.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// Circular FIFO with a combinational head; a push while full is accepted only when a pop frees a slot.
module link_fifo
  import chip_link_pkg::*;
#(
  parameter int W = 36,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2_min1(D);
  localparam int CW = $clog2(D + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(D - 1);
  localparam logic [CW-1:0] DEPTH    = CW'(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is not reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chip_link_port.sv
// Bridges a mesh edge port to an off-chip phit link: egress FIFO + serializer,
// ingress deserializer + credit-gated delivery back into the mesh.
module chip_link_port
  import chip_link_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int B  = B_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [FW-1:0] noc_flit_in,
  input  logic          noc_flit_in_wr,
  output logic          noc_credit_out,
  output logic [FW-1:0] noc_flit_out,
  output logic          noc_flit_out_wr,
  input  logic          noc_credit_in,
  output logic [PW-1:0] tx_phit,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [PW-1:0] rx_phit,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [1:0]    err
);

  // FW must be a whole number of phits.
  localparam int NB = FW / PW;
  localparam int BW = clog2_min1(NB);
  localparam int CW = $clog2(B + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(NB - 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(B);

  // ---------------- egress: FIFO + serializer ----------------
  ser_state_t    state;
  logic [FW-1:0] shreg;
  logic [BW-1:0] tx_beat;
  logic [FW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          last_accept;

  link_fifo #(.W(FW), .D(B)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (noc_flit_in_wr),
    .push_data (noc_flit_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Reloading on the final accepted beat keeps back-to-back flits bubble-free.
  assign last_accept = (state == ST_SEND) && tx_ready && (tx_beat == LAST_BEAT);
  assign fifo_pop    = !fifo_empty && ((state == ST_IDLE) || last_accept);
  assign tx_phit     = shreg[PW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      shreg          <= '0;
      tx_beat        <= '0;
      tx_valid       <= 1'b0;
      noc_credit_out <= 1'b0;
    end else begin
      noc_credit_out <= fifo_pop;
      if (fifo_pop) begin
        shreg    <= fifo_head;
        tx_beat  <= '0;
        tx_valid <= 1'b1;
        state    <= ST_SEND;
      end else if (state == ST_SEND && tx_ready) begin
        shreg <= shreg >> PW;
        if (tx_beat == LAST_BEAT) begin
          tx_beat  <= '0;
          tx_valid <= 1'b0;
          state    <= ST_IDLE;
        end else begin
          tx_beat <= tx_beat + 1'b1;
        end
      end
    end
  end

  // ---------------- ingress: deserializer + credit gate ----------------
  logic [BW-1:0] rx_beat;
  logic [FW-1:0] rx_flit;
  logic          hold_valid;
  logic [CW-1:0] credit_cnt;
  logic          rx_accept;
  logic          send;
  logic          fifo_overflow;
  logic          credit_overflow;

  assign rx_ready  = !rst && !hold_valid;
  assign rx_accept = rx_valid && rx_ready;
  assign send      = hold_valid && (credit_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_beat         <= '0;
      rx_flit         <= '0;
      hold_valid      <= 1'b0;
      noc_flit_out    <= '0;
      noc_flit_out_wr <= 1'b0;
    end else begin
      noc_flit_out_wr <= send;
      if (send) begin
        noc_flit_out <= rx_flit;
        hold_valid   <= 1'b0;
      end
      if (rx_accept) begin
        rx_flit[PW*rx_beat +: PW] <= rx_phit;
        if (rx_beat == LAST_BEAT) begin
          rx_beat    <= '0;
          hold_valid <= 1'b1;
        end else begin
          rx_beat <= rx_beat + 1'b1;
        end
      end
    end
  end

  assign fifo_overflow   = noc_flit_in_wr && fifo_full && !fifo_pop;
  assign credit_overflow = noc_credit_in && !send && (credit_cnt == CREDIT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CREDIT_MAX;
      err        <= '0;
    end else begin
      case ({send, noc_credit_in})
        2'b10:   credit_cnt <= credit_cnt - 1'b1;
        2'b01:   if (credit_cnt != CREDIT_MAX) credit_cnt <= credit_cnt + 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
      if (fifo_overflow)   err[0] <= 1'b1;
      if (credit_overflow) err[1] <= 1'b1;
    end
  end

endmodule
